// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction-fetch front end: issues word fetches from a local PC and
// buffers {IR, NPC} pairs in a small FIFO that feeds decode over valid/ready.
module mips32_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 10
) (
   input  logic                     clk1,
   input  logic                     rst_n,
   output logic                     imem_req,
   output logic [AW-1:0]            imem_addr,
   input  logic [31:0]              imem_rdata,
   input  logic                     redirect_valid,
   input  logic [31:0]              redirect_pc,
   input  logic                     halt,
   output logic                     id_valid,
   input  logic                     id_ready,
   output logic [31:0]              id_ir,
   output logic [31:0]              id_npc,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Handshake: a head entry leaves when id_valid && id_ready in a cycle with
   // no halt and no redirect; id_valid never depends on id_ready.
   logic [31:0]   ir_q  [DEPTH];
   logic [31:0]   npc_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   tag_q, tag_d;
   logic          inflight_q, inflight_d;
   logic          stopped_q, stopped_d;
   logic          run_q;

   logic rsp_hlt;
   logic credit_ok;
   logic issue;
   logic push;
   logic pop;

   assign rsp_hlt   = inflight_q && (imem_rdata[31:26] == 6'b111111);
   // The in-flight word already owns a slot, so pending + held must stay below DEPTH.
   assign credit_ok = (count_q + CW'(inflight_q)) < CW'(DEPTH);
   assign issue     = run_q && !halt && !redirect_valid && !stopped_q && !rsp_hlt && credit_ok;
   assign push      = inflight_q && !redirect_valid;
   assign pop       = id_valid && id_ready && !halt && !redirect_valid;

   assign imem_req  = issue;
   assign imem_addr = pc_q[AW-1:0];
   assign id_valid  = (count_q != '0);
   assign id_ir     = id_valid ? ir_q[rd_ptr_q]  : '0;
   assign id_npc    = id_valid ? npc_q[rd_ptr_q] : '0;
   assign occupancy = count_q;

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      pc_d       = pc_q;
      tag_d      = tag_q;
      inflight_d = inflight_q;
      stopped_d  = stopped_q;
      if (redirect_valid) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         pc_d       = redirect_pc;
         stopped_d  = 1'b0;
         inflight_d = 1'b0;
      end else begin
         inflight_d = issue;
         if (issue) begin
            tag_d = pc_q;
            pc_d  = pc_q + 32'd1;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (rsp_hlt) begin
               stopped_d = 1'b1;
            end
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         pc_q       <= '0;
         tag_q      <= '0;
         inflight_q <= 1'b0;
         stopped_q  <= 1'b0;
         run_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            ir_q[i]  <= '0;
            npc_q[i] <= '0;
         end
      end else begin
         run_q      <= 1'b1;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         pc_q       <= pc_d;
         tag_q      <= tag_d;
         inflight_q <= inflight_d;
         stopped_q  <= stopped_d;
         if (push) begin
            ir_q[wr_ptr_q]  <= imem_rdata;
            npc_q[wr_ptr_q] <= tag_q + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Bench for mips32_fetch_queue: memory model, scoreboard of expected {IR, NPC}
// pops, a per-cycle vector table for the fill/backpressure case, directed corners.
module tb_mips32_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 10;
  localparam logic [31:0] HLT = 32'hFC00_0000;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = 32'hDEAD_BEEF;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          halt = 1'b0;
  logic          id_valid;
  logic          id_ready = 1'b0;
  logic [31:0]   id_ir;
  logic [31:0]   id_npc;
  logic [2:0]    occupancy;

  mips32_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .id_valid(id_valid), .id_ready(id_ready), .id_ir(id_ir), .id_npc(id_npc),
    .occupancy(occupancy)
  );

  always #5 clk1 = ~clk1;

  logic [31:0] mem [1024];
  always @(posedge clk1) imem_rdata <= imem_req ? mem[imem_addr] : 32'hDEAD_BEEF;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  logic [63:0]   exp_q[$];
  logic [63:0]   exp_w;
  logic [AW-1:0] req_log[$];
  int            req_cyc[$];

  typedef struct packed {
    logic          rv;
    logic          rdy;
    logic          exp_req;
    logic [AW-1:0] exp_addr;
    logic [2:0]    exp_occ;
  } vec_t;
  vec_t tbl [18];

  function automatic logic [31:0] addi(input int a);
    logic [15:0] imm;
    imm = 16'(a);
    return {6'b001000, 5'd1, 5'd1, imm};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({mem[pc[AW-1:0]], pc + 32'd1});
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || occupancy != 0 || imem_req) && n < 300) begin
      tick();
      n++;
    end
    check({name, "_done"}, (n < 300), 1);
  endtask

  // Scoreboard: every accepted head entry must match the oldest expected pair.
  always @(negedge clk1) begin
    if (rst_n) begin
      if (imem_req) begin
        req_log.push_back(imem_addr);
        req_cyc.push_back(cyc);
      end
      if (id_valid && id_ready && !halt && !redirect_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got ir=%h npc=%h, expected no pop", id_ir, id_npc);
        end else begin
          exp_w = exp_q.pop_front();
          if ({id_ir, id_npc} !== exp_w) begin
            errors++;
            $display("FAIL pop_data: got ir=%h npc=%h expected ir=%h npc=%h",
                     id_ir, id_npc, exp_w[63:32], exp_w[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    int occ_prev;
    logic seen4;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 10'd0,   3'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 10'd100, 3'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 10'd101, 3'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 10'd102, 3'd1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 10'd103, 3'd2};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 10'd0,   3'd3};
    for (int i = 6; i <= 10; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 10'd0, 3'd4};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 10'd0,   3'd4};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 10'd104, 3'd3};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 10'd105, 3'd2};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 10'd0,   3'd2};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 10'd0,   3'd2};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 10'd0,   3'd1};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 10'd0,   3'd0};

    for (int i = 0; i < 1024; i++) mem[i] = addi(i);

    // reset values
    #1 rst_n = 1'b0;
    @(posedge clk1);
    @(posedge clk1);
    #1;
    check("rst_req", imem_req, 0);
    check("rst_valid", id_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_ir", id_ir, 0);
    check("rst_npc", id_npc, 0);

    // 1: streaming from address 0, one per cycle
    mem[6] = HLT;
    for (int a = 0; a <= 6; a++) push_exp(a);
    id_ready = 1'b1;
    @(negedge clk1);
    rst_n = 1'b1;
    rel = cyc;
    req_log.delete();
    req_cyc.delete();
    drain("t1");
    check("t1_nreq", req_log.size(), 7);
    if (req_cyc.size() > 0) check("t1_first_req_cycle", req_cyc[0], rel + 1);
    for (int i = 0; i < 7 && i < req_log.size(); i++) begin
      check("t1_addr", req_log[i], i);
      if (i > 0) check("t1_back_to_back", req_cyc[i] - req_cyc[i-1], 1);
    end

    // 2: fill to DEPTH under backpressure, then drain
    mem[105] = HLT;
    for (int a = 100; a <= 105; a++) push_exp(a);
    for (int i = 0; i < 18; i++) begin
      redirect_valid = tbl[i].rv;
      redirect_pc    = 32'd100;
      id_ready       = tbl[i].rdy;
      @(negedge clk1);
      check("t2_req", imem_req, tbl[i].exp_req);
      if (tbl[i].exp_req) check("t2_addr", imem_addr, tbl[i].exp_addr);
      check("t2_occ", occupancy, tbl[i].exp_occ);
      check("t2_valid", id_valid, (tbl[i].exp_occ != 0));
      tick();
    end
    redirect_valid = 1'b0;
    check("t2_sb_empty", exp_q.size(), 0);

    // 3: redirect with 3 queued and 1 in flight
    mem[23] = HLT;
    id_ready = 1'b0;
    do_redirect(32'd200);
    for (int i = 0; i < 4; i++) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'd20;
    id_ready       = 1'b1;
    for (int a = 20; a <= 23; a++) push_exp(a);
    @(negedge clk1);
    check("t3_occ_before", occupancy, 3);
    check("t3_req_full", imem_req, 0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk1);
    check("t3_occ_flushed", occupancy, 0);
    check("t3_req", imem_req, 1);
    check("t3_addr", imem_addr, 20);
    drain("t3");

    // 4: HLT at word 3 stops fetching; redirect resumes
    mem[3] = HLT;
    mem[4] = addi(4);
    for (int a = 0; a <= 3; a++) push_exp(a);
    req_log.delete();
    do_redirect(32'd0);
    drain("t4a");
    seen4 = 1'b0;
    foreach (req_log[i]) if (req_log[i] == 10'd4) seen4 = 1'b1;
    check("t4_no_addr4", seen4, 0);
    check("t4_nreq", req_log.size(), 4);
    for (int a = 0; a <= 3; a++) push_exp(a);
    req_log.delete();
    do_redirect(32'd0);
    drain("t4b");
    check("t4_resume_nreq", req_log.size(), 4);
    if (req_log.size() > 0) check("t4_resume_addr", req_log[0], 0);

    // 5: halt for 5 cycles mid-stream
    mem[316] = HLT;
    for (int a = 300; a <= 316; a++) push_exp(a);
    do_redirect(32'd300);
    for (int i = 0; i < 5; i++) tick();
    halt = 1'b1;
    occ_prev = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk1);
      check("t5_no_req", imem_req, 0);
      if (k >= 2) check("t5_occ_held", occupancy, occ_prev);
      occ_prev = int'(occupancy);
      tick();
    end
    halt = 1'b0;
    drain("t5");

    // 6: async reset with 2 entries queued
    id_ready = 1'b0;
    do_redirect(32'd400);
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk1);
    check("t6_occ_before", occupancy, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_req", imem_req, 0);
    check("t6_addr", imem_addr, 0);
    check("t6_valid", id_valid, 0);
    check("t6_ir", id_ir, 0);
    check("t6_npc", id_npc, 0);
    check("t6_occ", occupancy, 0);
    @(posedge clk1);
    @(posedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;
    rel = cyc;
    req_log.delete();
    req_cyc.delete();
    for (int a = 0; a <= 3; a++) push_exp(a);
    id_ready = 1'b1;
    drain("t6");
    if (req_log.size() > 0) check("t6_restart_addr", req_log[0], 0);
    if (req_cyc.size() > 0) check("t6_restart_cycle", req_cyc[0], rel + 1);

    // 7: PC wrap at 2^32 and imem_addr truncation at 2^AW
    push_exp(32'hFFFF_FFFF);
    for (int a = 0; a <= 3; a++) push_exp(a);
    do_redirect(32'hFFFF_FFFF);
    @(negedge clk1);
    check("t7_addr_top", imem_addr, 1023);
    drain("t7a");
    push_exp(32'd1029);
    push_exp(32'd1030);
    do_redirect(32'd1029);
    @(negedge clk1);
    check("t7_addr_trunc", imem_addr, 5);
    drain("t7b");

    check("final_sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
